logreg_mac_sched: RTL and testbench

Sequencer that time-shares one 7×32-bit multiply-accumulate unit to compute the logistic-regression inner products for every class of a one-vs-all classifier. It accepts one line-buffer window of `NUM_FEAT` pixels and walks a synchronous theta ROM feature by feature, class by class. It emits one 32-bit `hprime` per class and, optionally, the winning class index. It sits between the line buffer and the sigmoid/threshold stage, and replaces per-class fully parallel inner-product arrays.

---
 rtl/logreg_mac_sched.sv | 161 ++++++++++++++++
 tb/tb_logreg_mac_sched.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/logreg_mac_sched.sv
// Time-shared MAC sequencer: per-class inner products of a pixel window against a theta ROM.
// Optional argmax over the per-class results is built when LOGREG_ARGMAX_EN is defined.
module logreg_mac_sched #(
  parameter int NUM_FEAT  = 81,
  parameter int NUM_CLASS = 10,
  parameter int XW        = 7,
  parameter int TW        = 32,
  parameter int AW        = $clog2(NUM_CLASS*NUM_FEAT),
  parameter int CW        = $clog2(NUM_CLASS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [NUM_FEAT*XW-1:0] xarray_i,
  output logic [AW-1:0]          theta_addr_o,
  input  logic [TW-1:0]          theta_data_i,
  output logic                   hp_valid_o,
  output logic [TW-1:0]          hprime_o,
  output logic [CW-1:0]          hp_class_o,
  output logic                   done_o,
  output logic [CW-1:0]          best_class_o
);
  localparam int KW = $clog2(NUM_FEAT+1);
  localparam logic [KW-1:0] K_END  = KW'(NUM_FEAT);
  localparam logic [CW-1:0] C_LAST = CW'(NUM_CLASS-1);

  typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_e;
  state_e state_q, state_d;

  logic [NUM_FEAT-1:0][XW-1:0] win_q, win_d;
  logic [CW-1:0] c_q, c_d, hpc_q, hpc_d;
  logic [KW-1:0] k_q, k_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          issue_q, issue_d;
  logic [XW-1:0] xk_q, xk_d;
  logic [TW-1:0] acc_q, acc_d, hprime_q, hprime_d;

  // State register and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      win_q    <= '0;
      c_q      <= '0;
      k_q      <= '0;
      addr_q   <= '0;
      issue_q  <= 1'b0;
      xk_q     <= '0;
      acc_q    <= '0;
      hprime_q <= '0;
      hpc_q    <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      c_q      <= c_d;
      k_q      <= k_d;
      addr_q   <= addr_d;
      issue_q  <= issue_d;
      xk_q     <= xk_d;
      acc_q    <= acc_d;
      hprime_q <= hprime_d;
      hpc_q    <= hpc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid_i) state_d = MAC;
      MAC:  if (k_q == K_END && issue_q) state_d = EMIT;
      EMIT: state_d = (c_q == C_LAST) ? DONE : MAC;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values. The address counter runs straight through all classes,
  // so c*NUM_FEAT+k never needs a multiplier.
  always_comb begin
    win_d    = win_q;
    c_d      = c_q;
    k_d      = k_q;
    addr_d   = addr_q;
    issue_d  = 1'b0;
    xk_d     = xk_q;
    acc_d    = acc_q;
    hprime_d = hprime_q;
    hpc_d    = hpc_q;
    case (state_q)
      IDLE: if (in_valid_i) begin
        win_d  = xarray_i;
        c_d    = '0;
        k_d    = '0;
        addr_d = '0;
        acc_d  = '0;
      end
      MAC: begin
        if (k_q < K_END) begin
          issue_d = 1'b1;
          xk_d    = win_q[k_q];
          k_d     = k_q + 1'b1;
          addr_d  = addr_q + 1'b1;
        end
        // Low TW bits of the unsigned product equal signed theta x zero-extended pixel
        if (issue_q) acc_d = acc_q + (theta_data_i * TW'(xk_q));
        if (state_d == EMIT) begin
          hprime_d = acc_d;
          hpc_d    = c_q;
        end
      end
      EMIT: if (c_q != C_LAST) begin
        c_d   = c_q + 1'b1;
        k_d   = '0;
        acc_d = '0;
      end
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready_o = (state_q == IDLE) && !rst_i;
    hp_valid_o = (state_q == EMIT);
    done_o     = (state_q == DONE);
  end

  assign theta_addr_o = addr_q;
  assign hprime_o     = hprime_q;
  assign hp_class_o   = hpc_q;

`ifdef LOGREG_ARGMAX_EN
  logic [CW-1:0] best_q, best_d;
  logic [TW-1:0] bestv_q, bestv_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      best_q  <= '0;
      bestv_q <= '0;
    end else begin
      best_q  <= best_d;
      bestv_q <= bestv_d;
    end
  end

  // Strictly greater replaces, so ties keep the lowest class index
  always_comb begin
    best_d  = best_q;
    bestv_d = bestv_q;
    if (state_q == EMIT && (c_q == '0 || $signed(hprime_q) > $signed(bestv_q))) begin
      best_d  = c_q;
      bestv_d = hprime_q;
    end
  end

  assign best_class_o = best_q;
`else
  assign best_class_o = '0;
`endif

endmodule

// File: tb/tb_logreg_mac_sched.sv
// Directed bench for logreg_mac_sched: table of window/theta patterns plus busy and reset sequences.
module tb_logreg_mac_sched;
  localparam int NF = 81;
  localparam int NC = 10;
  localparam int XW = 7;
  localparam int TW = 32;
  localparam int AW = $clog2(NC*NF);
  localparam int CW = $clog2(NC);
  localparam int PER = NF + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [NF*XW-1:0] xarray = '0;
  logic [AW-1:0] theta_addr;
  logic [TW-1:0] theta_data = '0;
  logic hp_valid, done;
  logic [TW-1:0] hprime;
  logic [CW-1:0] hp_class, best_class;

  int checks = 0;
  int errors = 0;
  int tmode = 0;

  logreg_mac_sched dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .xarray_i(xarray), .theta_addr_o(theta_addr), .theta_data_i(theta_data),
    .hp_valid_o(hp_valid), .hprime_o(hprime), .hp_class_o(hp_class),
    .done_o(done), .best_class_o(best_class)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input int a);
    int c;
    c = a / NF;
    case (tmode)
      0:       return (c == 0) ? 32'd1 : 32'(c);
      1:       return (c == 3) ? 32'hFFFF_FFFF : 32'd0;
      default: return (c == 0) ? 32'h7FFF_FFFF : 32'd0;
    endcase
  endfunction

  always @(posedge clk) theta_data <= rom(int'(theta_addr));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]             pmode;
    logic [1:0]             tmode;
    logic [NC-1:0][31:0]    exp_h;
    logic [3:0]             exp_best;
  } vec_t;

  vec_t vecs [3];
  logic [31:0] got_h [NC];
  int          got_c [NC];
  int          got_t [NC];

  task automatic run_window(input int pm, input int tm, input logic [NC-1:0][31:0] exp_h,
                            input logic [3:0] exp_best, input bit busy_poke, input bit rst_mid);
    int nhp, ndone, done_t, early, r832;
    logic [CW-1:0] got_best;
    logic [3:0] eb;
    nhp = 0; ndone = 0; done_t = -1; early = 0; r832 = 0; got_best = '0;
`ifdef LOGREG_ARGMAX_EN
    eb = exp_best;
`else
    eb = 4'd0;
`endif
    tmode = tm;
    for (int k = 0; k < NF; k++)
      xarray[k*XW +: XW] = (pm == 0) ? 7'd1 : (pm == 1) ? 7'(k % 128) : 7'd127;
    @(negedge clk);
    in_valid = 1'b1;
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    for (int t = 1; t <= 845; t++) begin
      @(negedge clk);
      if (t == 1) in_valid = 1'b0;
      if (busy_poke && t == 5) begin
        in_valid = 1'b1;
        xarray = ~xarray;
      end
      if (busy_poke && t == 6) in_valid = 1'b0;
      if (hp_valid) begin
        if (nhp < NC) begin
          got_h[nhp] = hprime;
          got_c[nhp] = int'(hp_class);
          got_t[nhp] = t;
        end
        nhp++;
      end
      if (done) begin
        ndone++;
        done_t = t;
        got_best = best_class;
      end
      if (!rst_mid) begin
        if (t < 832 && in_ready) early++;
        if (t == 832) r832 = int'(in_ready);
      end else begin
        if (t == 200) rst = 1'b1;
        if (t == 201) begin
          chk("rst_ready_low", {31'd0, in_ready}, 32'd0);
          rst = 1'b0;
        end
        if (t == 202) begin
          chk("rst_ready_high", {31'd0, in_ready}, 32'd1);
          chk("rst_hprime", hprime, 32'd0);
          chk("rst_hp_class", 32'(hp_class), 32'd0);
          chk("rst_best", 32'(best_class), 32'd0);
        end
      end
    end
    if (!rst_mid) begin
      chk("hp_count", 32'(nhp), 32'(NC));
      for (int c = 0; c < NC && c < nhp; c++) begin
        chk($sformatf("hprime_c%0d", c), got_h[c], exp_h[c]);
        chk($sformatf("hp_class_c%0d", c), 32'(got_c[c]), 32'(c));
        chk($sformatf("hp_cycle_c%0d", c), 32'(got_t[c]), 32'((c + 1) * PER));
      end
      chk("done_count", 32'(ndone), 32'd1);
      chk("done_cycle", 32'(done_t), 32'(NC * PER + 1));
      chk("best_class", 32'(got_best), 32'(eb));
      chk("ready_early", 32'(early), 32'd0);
      chk("ready_832", 32'(r832), 32'd1);
    end else begin
      chk("rst_hp_count", 32'(nhp), 32'd2);
      chk("rst_done_count", 32'(ndone), 32'd0);
      for (int c = 0; c < 2 && c < nhp; c++)
        chk($sformatf("rst_hprime_c%0d", c), got_h[c], (c == 0) ? 32'd81 : 32'd81);
    end
  endtask

  initial begin
    vecs[0].pmode = 2'd0; vecs[0].tmode = 2'd0; vecs[0].exp_best = 4'd9;
    vecs[0].exp_h = '0;
    vecs[0].exp_h[0] = 32'd81;  vecs[0].exp_h[1] = 32'd81;  vecs[0].exp_h[2] = 32'd162;
    vecs[0].exp_h[3] = 32'd243; vecs[0].exp_h[4] = 32'd324; vecs[0].exp_h[5] = 32'd405;
    vecs[0].exp_h[6] = 32'd486; vecs[0].exp_h[7] = 32'd567; vecs[0].exp_h[8] = 32'd648;
    vecs[0].exp_h[9] = 32'd729;
    vecs[1].pmode = 2'd1; vecs[1].tmode = 2'd1; vecs[1].exp_best = 4'd0;
    vecs[1].exp_h = '0;
    vecs[1].exp_h[3] = 32'hFFFF_F358;
    // 81*127 is odd, so 10287*(2^31-1) mod 2^32 = 2^31 - 10287
    vecs[2].pmode = 2'd2; vecs[2].tmode = 2'd2; vecs[2].exp_best = 4'd0;
    vecs[2].exp_h = '0;
    vecs[2].exp_h[0] = 32'h7FFF_D7D1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_hp_valid", {31'd0, hp_valid}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_theta_addr", 32'(theta_addr), 32'd0);
    chk("reset_hprime", hprime, 32'd0);
    chk("reset_hp_class", 32'(hp_class), 32'd0);
    chk("reset_best", 32'(best_class), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 3; i++)
      run_window(int'(vecs[i].pmode), int'(vecs[i].tmode), vecs[i].exp_h, vecs[i].exp_best, i == 0, 1'b0);

    run_window(0, 0, vecs[0].exp_h, vecs[0].exp_best, 1'b0, 1'b1);
    run_window(0, 0, vecs[0].exp_h, vecs[0].exp_best, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
